// File: rtl/mont_mul_seq_if.sv
// Operand/result bundle for the sequential Montgomery multiplier.
// The master side issues start/abort and operands; the slave returns the result and status.
interface mont_mul_seq_if #(
    parameter int WID = 256
);
    logic           start;
    logic           abort;
    logic [WID-1:0] a;
    logic [WID-1:0] b;
    logic [WID-1:0] m;
    logic [WID-1:0] r;
    logic           busy;
    logic           done;
    logic           err;

    modport master (output start, abort, a, b, m, input r, busy, done, err);
    modport slave  (input start, abort, a, b, m, output r, busy, done, err);
endinterface

// File: rtl/mont_mul_seq.sv
// Sequential Montgomery modular multiplier: r = a*b*2^-WID mod m.
// Each RUN cycle consumes DIGW bits of a, LSB first, as DIGW chained radix-2 steps.
// A single FIN cycle then applies the final conditional subtraction.
//
//  state | meaning
//  IDLE  | waiting for start; operands are latched on accept
//  RUN   | one digit of a folded into acc per cycle
//  FIN   | final subtraction, result registered, done pulsed
module mont_mul_seq #(
    parameter int WID  = 256,
    parameter int DIGW = 1,
    parameter int CNTW = 8
) (
    input  logic           clk,
    input  logic           rst,
    mont_mul_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam int              STEPS = WID / DIGW;
    localparam logic [CNTW-1:0] LAST  = CNTW'(STEPS - 1);

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic [CNTW-1:0] cnt;
    logic [WID:0]    acc;
    logic [WID:0]    acc_nxt;
    logic [WID+1:0]  t;
    logic [WID-1:0]  a_sh;
    logic [WID-1:0]  b_q;
    logic [WID-1:0]  m_q;
    logic [WID-1:0]  r_q;
    logic [WID-1:0]  diff;
    logic            ge;
    logic            done_q;
    logic            err_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; an even modulus is rejected without leaving IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (bus.m[0]) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // DIGW unrolled radix-2 steps; acc stays below 2m, so t fits in WID+2 bits.
    always_comb begin
        acc_nxt = acc;
        t       = '0;
        for (int j = 0; j < DIGW; j++) begin
            t       = {1'b0, acc_nxt} + (a_sh[j] ? {2'b00, b_q} : '0);
            t       = t + (t[0] ? {2'b00, m_q} : '0);
            acc_nxt = t[WID+1:1];
        end
    end

    // Final subtraction; the result is truncated to WID bits either way.
    always_comb begin
        ge   = (acc >= {1'b0, m_q});
        diff = acc[WID-1:0] - m_q;
    end

    // Datapath: operand latch, digit iteration, result register and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            a_sh   <= '0;
            b_q    <= '0;
            m_q    <= '0;
            r_q    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_sh  <= bus.a;
                b_q   <= bus.b;
                m_q   <= bus.m;
                acc   <= '0;
                cnt   <= '0;
                err_q <= 1'b0;
                if (!bus.m[0]) begin
                    r_q    <= '0;
                    err_q  <= 1'b1;
                    done_q <= 1'b1;
                end
            end else if (state != IDLE && bus.abort) begin
                acc <= '0;
                cnt <= '0;
            end else if (state == RUN) begin
                acc  <= acc_nxt;
                a_sh <= a_sh >> DIGW;
                cnt  <= cnt + 1'b1;
            end else if (state == FIN) begin
                r_q    <= ge ? diff : acc[WID-1:0];
                done_q <= 1'b1;
            end
        end
    end

    assign bus.r    = r_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_mont_mul_seq.sv
// Bench for mont_mul_seq: five parameter sets driven through their interfaces,
// a full-product reference model, and one per-cycle compare process.
module tb_mont_mul_seq;
    localparam int NI = 5;

    function automatic int wid_of(input int i);
        return (i < 2) ? 8 : 256;
    endfunction

    function automatic int dig_of(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            2:       return 1;
            3:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int steps_of(input int i);
        return wid_of(i) / dig_of(i);
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Count of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    logic         start_d [NI];
    logic         abort_d [NI];
    logic [255:0] a_d [NI];
    logic [255:0] b_d [NI];
    logic [255:0] m_d [NI];
    logic [255:0] r_o [NI];
    logic         busy_o [NI];
    logic         done_o [NI];
    logic         err_o [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g
        localparam int W = wid_of(gi);
        mont_mul_seq_if #(.WID(W)) bus ();
        assign bus.start  = start_d[gi];
        assign bus.abort  = abort_d[gi];
        assign bus.a      = a_d[gi][W-1:0];
        assign bus.b      = b_d[gi][W-1:0];
        assign bus.m      = m_d[gi][W-1:0];
        assign r_o[gi]    = 256'(bus.r);
        assign busy_o[gi] = bus.busy;
        assign done_o[gi] = bus.done;
        assign err_o[gi]  = bus.err;
        mont_mul_seq #(.WID(W), .DIGW(dig_of(gi)), .CNTW(8)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int idx, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, idx, cyc, act, exp);
        end
    endtask

    // Reference: reduce the full product, then halve mod m WID times (multiply by 2^-WID).
    function automatic logic [255:0] ref_mont(input logic [255:0] a, input logic [255:0] b,
                                              input logic [255:0] m, input int wid);
        logic [511:0] p;
        logic [257:0] x;
        p = {256'd0, a} * {256'd0, b};
        x = 258'(p % {256'd0, m});
        for (int k = 0; k < wid; k++) begin
            x = x[0] ? ((x + {2'b00, m}) >> 1) : (x >> 1);
        end
        return x[255:0];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    typedef struct {
        int           inst;
        int           acc;
        int           dcyc;
        logic [255:0] r;
        logic         err;
    } op_t;

    op_t          pend[$];
    logic         cur_act [NI];
    int           cur_done [NI];
    logic [255:0] cur_r [NI];
    logic         cur_err [NI];
    logic [255:0] r_exp [NI];
    logic         err_exp [NI];
    int           abort_at [NI] = '{default: -1};

    // Compare process: expected busy/done/r/err for every instance on every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                cur_act[i] = 1'b0;
                r_exp[i]   = '0;
                err_exp[i] = 1'b0;
            end
            pend.delete();
        end
        for (int i = 0; i < NI; i++) begin
            bit eb, ed;
            if (pend.size() > 0 && pend[0].inst == i && pend[0].acc == cyc) begin
                cur_act[i]  = 1'b1;
                cur_done[i] = pend[0].dcyc;
                cur_r[i]    = pend[0].r;
                cur_err[i]  = pend[0].err;
                err_exp[i]  = 1'b0;
                void'(pend.pop_front());
            end
            if (abort_at[i] == cyc) cur_act[i] = 1'b0;
            eb = cur_act[i] && (cyc < cur_done[i]);
            ed = cur_act[i] && (cyc == cur_done[i]);
            if (ed) begin
                r_exp[i]   = cur_r[i];
                err_exp[i] = cur_err[i];
                cur_act[i] = 1'b0;
            end
            chk("busy", i, 256'(busy_o[i]), 256'(eb));
            chk("done", i, 256'(done_o[i]), 256'(ed));
            chk("r",    i, r_o[i], r_exp[i]);
            chk("err",  i, 256'(err_o[i]), 256'(err_exp[i]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int i, input logic [255:0] a, input logic [255:0] b,
                            input logic [255:0] m, output int e);
        op_t op;
        a_d[i]     = a;
        b_d[i]     = b;
        m_d[i]     = m;
        start_d[i] = 1'b1;
        e          = cyc + 1;
        op.inst    = i;
        op.acc     = e;
        if (m[0]) begin
            op.dcyc = e + steps_of(i) + 1;
            op.r    = ref_mont(a, b, m, wid_of(i));
            op.err  = 1'b0;
        end else begin
            op.dcyc = e;
            op.r    = '0;
            op.err  = 1'b1;
        end
        pend.push_back(op);
        tick();
        start_d[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int e, input int lat, input logic [255:0] rx,
                             input string nm);
        int n = 0;
        while (!done_o[i] && n < 600) begin
            tick();
            n++;
        end
        chk({nm, " latency"}, i, 256'(cyc - e), 256'(lat));
        chk({nm, " r"}, i, r_o[i], rx);
        chk({nm, " err"}, i, 256'(err_o[i]), 256'd0);
    endtask

    task automatic gen_ops(input int i, output logic [255:0] a, output logic [255:0] b,
                           output logic [255:0] m);
        if (wid_of(i) == 8) begin
            m = 256'($urandom_range(0, 127) * 2 + 1);
            a = 256'($urandom_range(0, 255)) % m;
            b = 256'($urandom_range(0, 255)) % m;
        end else begin
            m = rnd256() | 256'd1;
            a = rnd256() % m;
            b = rnd256() % m;
        end
    endtask

    // Back-to-back operations started on each done cycle; operands scrambled after accept
    // and occasional start pulses while busy that must be ignored.
    task automatic run_random(input int i, input int nops);
        logic [255:0] a, b, m;
        int e, d, c, n;
        n = steps_of(i);
        gen_ops(i, a, b, m);
        do_start(i, a, b, m, e);
        for (int k = 1; k <= nops; k++) begin
            d = e + n + 1;
            a_d[i] = rnd256();
            b_d[i] = rnd256();
            m_d[i] = rnd256();
            if ($urandom_range(0, 1) == 1) begin
                c = e + $urandom_range(0, n);
                while (cyc < c) tick();
                a_d[i]     = rnd256();
                start_d[i] = 1'b1;
                tick();
                start_d[i] = 1'b0;
            end
            while (cyc < d) tick();
            if (k < nops) begin
                gen_ops(i, a, b, m);
                do_start(i, a, b, m, e);
            end
        end
        tick();
        tick();
    endtask

    initial begin
        int e;
        bit saw;
        logic [255:0] a, b, m;
        for (int i = 0; i < NI; i++) begin
            start_d[i] = 1'b0;
            abort_d[i] = 1'b0;
            a_d[i]     = '0;
            b_d[i]     = '0;
            m_d[i]     = '0;
        end
        rst = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            chk("reset r",    i, r_o[i], 256'd0);
            chk("reset busy", i, 256'(busy_o[i]), 256'd0);
            chk("reset done", i, 256'(done_o[i]), 256'd0);
            chk("reset err",  i, 256'(err_o[i]), 256'd0);
        end
        chk("model 5*7 m13",     0, ref_mont(256'd5, 256'd7, 256'd13, 8), 256'd1);
        chk("model 254*254 m255", 0, ref_mont(256'd254, 256'd254, 256'd255, 8), 256'd1);
        chk("model 1*9 m13",     0, ref_mont(256'd1, 256'd9, 256'd13, 8), 256'd1);
        chk("model 3*4 m13",     0, ref_mont(256'd3, 256'd4, 256'd13, 8), 256'd10);
        rst = 1'b1;
        tick();
        tick();

        do_start(0, 256'd5, 256'd7, 256'd13, e);
        wait_done(0, e, 9, 256'd1, "d1 5*7");
        tick();
        do_start(0, 256'd254, 256'd254, 256'd255, e);
        wait_done(0, e, 9, 256'd1, "d1 254*254");
        do_start(0, 256'd1, 256'd9, 256'd13, e);
        wait_done(0, e, 9, 256'd1, "d1 1*9 b2b");

        // Abort mid-run, with an ignored start pulse while busy.
        do_start(0, 256'd5, 256'd7, 256'd13, e);
        a_d[0] = 256'd2;
        b_d[0] = 256'd3;
        tick();
        start_d[0] = 1'b1;
        tick();
        start_d[0] = 1'b0;
        tick();
        abort_d[0]  = 1'b1;
        abort_at[0] = cyc + 1;
        tick();
        abort_d[0] = 1'b0;
        chk("abort busy", 0, 256'(busy_o[0]), 256'd0);
        chk("abort r",    0, r_o[0], 256'd1);
        saw = 1'b0;
        repeat (12) begin
            tick();
            if (done_o[0]) saw = 1'b1;
        end
        chk("abort no done", 0, 256'(saw), 256'd0);

        // Abort landing on the final-subtraction cycle.
        do_start(0, 256'd3, 256'd4, 256'd13, e);
        while (cyc < e + 8) tick();
        abort_d[0]  = 1'b1;
        abort_at[0] = cyc + 1;
        tick();
        abort_d[0] = 1'b0;
        repeat (4) tick();
        chk("fin abort r", 0, r_o[0], 256'd1);

        // Abort while idle is harmless.
        abort_d[0] = 1'b1;
        tick();
        abort_d[0] = 1'b0;
        chk("idle abort busy", 0, 256'(busy_o[0]), 256'd0);
        do_start(0, 256'd5, 256'd7, 256'd13, e);
        wait_done(0, e, 9, 256'd1, "d1 after idle abort");
        tick();

        // Even modulus.
        do_start(0, 256'd5, 256'd7, 256'd12, e);
        chk("even done", 0, 256'(done_o[0]), 256'd1);
        chk("even err",  0, 256'(err_o[0]), 256'd1);
        chk("even r",    0, r_o[0], 256'd0);
        chk("even busy", 0, 256'(busy_o[0]), 256'd0);
        tick();
        chk("even done once", 0, 256'(done_o[0]), 256'd0);
        chk("even err held",  0, 256'(err_o[0]), 256'd1);

        do_start(1, 256'd5, 256'd7, 256'd13, e);
        wait_done(1, e, 3, 256'd1, "d4 5*7");
        do_start(1, 256'd0, 256'd7, 256'd13, e);
        wait_done(1, e, 3, 256'd0, "d4 0*7");
        tick();

        run_random(4, 300);
        run_random(3, 80);
        run_random(2, 12);
        run_random(0, 150);
        run_random(1, 150);

        // Reset asserted in the middle of an operation.
        gen_ops(3, a, b, m);
        do_start(3, a, b, m, e);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("midrst busy", 3, 256'(busy_o[3]), 256'd0);
        chk("midrst r",    3, r_o[3], 256'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        gen_ops(3, a, b, m);
        do_start(3, a, b, m, e);
        wait_done(3, e, 65, ref_mont(a, b, m, 256), "after reset");
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
